pipeline_stall_controller: RTL and testbench

Central sequencer for pipeline stalls and flushes in the 5-stage RISC-V core. It merges three sources into one set of per-stage stall/flush controls: the hazard unit's load-use stall, multi-cycle data-memory waits in M, and the iterative mul/div unit (MDU) in E. It also runs the MDU start/busy sequence, a memory-wait timeout watchdog and a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_controller_mem_wait_watchdog.sv | 39 +++
 rtl/pipeline_stall_controller.sv | 103 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Holds the MDU FSM state encoding and parameter defaults.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int MDU_LATENCY_DEF = 34;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/pipeline_stall_controller_mem_wait_watchdog.sv
// Memory-wait watchdog: counts M-stage wait cycles and forces a release
// at MEM_TIMEOUT, latching a sticky error. Ports: clk, reset, mem_req,
// mem_ready in; mem_stall, mem_timeout_err out.
module mem_wait_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_timeout_err
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  logic [WW-1:0] wait_cnt;
  logic          pending;
  logic          at_limit;

  assign pending   = mem_req & ~mem_ready;
  assign at_limit  = (wait_cnt == WW'(MEM_TIMEOUT));
  // At the limit the request is let through so M can drain.
  assign mem_stall = pending & ~at_limit & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (mem_stall) wait_cnt <= wait_cnt + 1'b1;
      else           wait_cnt <= '0;
      if (pending && at_limit) mem_timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Merges load-use, memory-wait and MDU stalls into per-stage stall/flush
// controls; runs the MDU start/busy FSM and a saturating stall counter.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lw_stall,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             mdu_start,
  output logic [1:0]       mdu_state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycle_count
);

  localparam int MW = $clog2(MDU_LATENCY);

  mdu_state_t    state;
  logic [MW-1:0] mdu_cnt;
  logic          mem_stall;
  logic          mdu_stall;
  logic          lw_q;
  logic          pc_q;
  logic          md_q;

  // Inputs are masked while reset is held so every output reads 0.
  assign lw_q = lw_stall & ~reset;
  assign pc_q = PCSrcE   & ~reset;
  assign md_q = MulDivE  & ~reset;

  mem_wait_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wd (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (MemReqM),
    .mem_ready      (MemReadyM),
    .mem_stall      (mem_stall),
    .mem_timeout_err(mem_timeout_err)
  );

  assign mdu_stall = ((state == IDLE) & md_q) | (state == BUSY);
  assign mdu_start = (state == IDLE) & md_q & ~mem_stall;
  assign mdu_state = state;

  assign StallE = mem_stall | mdu_stall;
  assign StallF = StallE | lw_q;
  assign StallD = StallF;
  assign StallM = mem_stall;
  assign FlushW = mem_stall;
  assign FlushM = mdu_stall & ~mem_stall;
  assign FlushE = (lw_q | pc_q) & ~StallE;
  assign FlushD = pc_q & ~StallE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mdu_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mdu_start) begin
            state   <= BUSY;
            mdu_cnt <= MW'(MDU_LATENCY - 2);
          end
        end
        // The unit runs on its own, so BUSY ignores M stalls.
        BUSY: begin
          if (mdu_cnt == '0) state <= DONE;
          else               mdu_cnt <= mdu_cnt - 1'b1;
        end
        DONE: begin
          if (!mem_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycle_count <= '0;
    end else if (StallF && (stall_cycle_count != '1)) begin
      stall_cycle_count <= stall_cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller.
// Expected values come from a cycle model and are queued per cycle.
module tb_pipeline_stall_controller;

  localparam int LAT = 4;
  localparam int TO  = 5;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic reset;
  logic lw_stall, PCSrcE, MulDivE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushM, FlushW;
  logic mdu_start;
  logic [1:0] mdu_state;
  logic mem_timeout_err;
  logic [CW-1:0] stall_cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0] ctl;
    logic [1:0] st;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  int m_st, m_cnt, m_wait, m_count;
  bit m_err;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MDU_LATENCY(LAT),
    .MEM_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .lw_stall(lw_stall), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .mdu_start(mdu_start), .mdu_state(mdu_state),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycle_count(stall_cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctl_now();
    return {StallF, StallD, StallE, StallM,
            FlushD, FlushE, FlushM, FlushW, mdu_start};
  endfunction

  function automatic exp_t predict();
    bit ms, ds, se, sf;
    exp_t e;
    ms = MemReqM && !MemReadyM && (m_wait != TO);
    ds = (m_st == 0 && MulDivE) || (m_st == 1);
    se = ms || ds;
    sf = se || lw_stall;
    e.ctl = {sf, sf, se, ms,
             PCSrcE && !se, (lw_stall || PCSrcE) && !se,
             ds && !ms, ms, (m_st == 0) && MulDivE && !ms};
    e.st  = 2'(m_st);
    e.err = m_err;
    e.cnt = 8'(m_count);
    return e;
  endfunction

  task automatic model_tick();
    bit ms, ds, sf, pend;
    pend = MemReqM && !MemReadyM;
    ms = pend && (m_wait != TO);
    ds = (m_st == 0 && MulDivE) || (m_st == 1);
    sf = ms || ds || lw_stall;
    if (pend && m_wait == TO) m_err = 1'b1;
    m_wait = ms ? m_wait + 1 : 0;
    if (sf && m_count < 255) m_count++;
    case (m_st)
      0: if (MulDivE && !ms) begin m_st = 1; m_cnt = LAT - 2; end
      1: if (m_cnt == 0) m_st = 2; else m_cnt--;
      default: if (!ms) m_st = 0;
    endcase
  endtask

  task automatic step(input bit lw, input bit pc, input bit md,
                      input bit req, input bit rdy);
    exp_t e;
    @(negedge clk);
    lw_stall = lw; PCSrcE = pc; MulDivE = md;
    MemReqM = req; MemReadyM = rdy;
    q.push_back(predict());
    #1;
    e = q.pop_front();
    check("ctl", 32'(ctl_now()), 32'(e.ctl));
    check("state", 32'(mdu_state), 32'(e.st));
    check("err", 32'(mem_timeout_err), 32'(e.err));
    check("cnt", 32'(stall_cycle_count), 32'(e.cnt));
    model_tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    lw_stall = 0; PCSrcE = 0; MulDivE = 0; MemReqM = 0; MemReadyM = 0;
    reset = 1'b1;
    m_st = 0; m_cnt = 0; m_wait = 0; m_count = 0; m_err = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    lw_stall = 0; PCSrcE = 0; MulDivE = 0; MemReqM = 0; MemReadyM = 0;
    #2;
    check("rst_ctl", 32'(ctl_now()), 32'h0);
    check("rst_st", 32'(mdu_state), 32'h0);
    check("rst_cnt", 32'(stall_cycle_count), 32'h0);
    do_reset();

    // MDU alone
    for (int c = 0; c < 7; c++) step(0, 0, c < 5, 0, 0);
    check("mdu_cnt4", 32'(stall_cycle_count), 32'd4);

    // Memory wait of 3 cycles
    do_reset();
    for (int c = 0; c < 6; c++) step(0, 0, 0, c < 4, c == 3);
    check("mem_err0", 32'(mem_timeout_err), 32'd0);
    check("mem_cnt3", 32'(stall_cycle_count), 32'd3);

    // Timeout
    do_reset();
    for (int c = 0; c < 6; c++) step(0, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0);
    check("to_err", 32'(mem_timeout_err), 32'd1);
    check("to_cnt5", 32'(stall_cycle_count), 32'd5);
    do_reset();
    check("to_clr", 32'(mem_timeout_err), 32'd0);

    // Load-use, plain branch, branch deferred behind MDU
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int c = 0; c < 6; c++) step(0, c < 5, c < 5, 0, 0);

    // MDU overlapped with memory wait
    do_reset();
    for (int c = 0; c < 9; c++)
      step(0, 0, c < 7, c >= 2 && c <= 6, c == 6);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 300; c++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0);

    // Counter saturation
    do_reset();
    for (int c = 0; c < 260; c++) step(1, 0, 0, 0, 0);
    check("sat", 32'(stall_cycle_count), 32'd255);

    // Asynchronous reset mid-BUSY
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_st", 32'(mdu_state), 32'h0);
    check("arst_ctl", 32'(ctl_now()), 32'h0);
    check("arst_cnt", 32'(stall_cycle_count), 32'h0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
